config_loader: RTL and testbench
================================

# config_loader

Initiator side of the configuration write bus. Issues single-cycle `config_en` write strobes with `config_addr`/`config_data` into the configuration register bank. After reset it replays a fixed boot sequence that programs all four configuration registers. After that it drains host commands from an internal FIFO, inserting a programmable idle gap between consecutive writes.

## Interface
- `BOOT_CH0`, 2'h0, value written to address 0 during boot
- `BOOT_CH1`, 2'h1, value written to address 1 during boot
- `BOOT_CH2`, 2'h2, value written to address 2 during boot
- `BOOT_CRC_EN`, 1'b0, value written to address 3 during boot, as `config_data = {1'b0, BOOT_CRC_EN}`
- `GAP_CYCLES`, 2, idle cycles between write strobes; legal range 0..15
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, at least 2

Ports:
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `cmd_valid`  input  1  host command present
- `cmd_data`  input  4  host command: `[3:2]` is the target address, `[1:0]` is the write data
- `cmd_ready`  output  1  FIFO can accept; `cmd_ready = !full`, combinational from the occupancy count
- `config_addr`  output  2  write address, registered
- `config_data`  output  2  write data, registered
- `config_en`  output  1  write strobe, registered, high for exactly one cycle per write
- `boot_done`  output  1  high once all four boot writes have been issued; stays high until reset
- `busy`  output  1  `!boot_done | fifo_not_empty | gap_cnt != 0 | config_en`

## Operation
- Reset (async assert) clears the following:
  - `config_addr`, `config_data`, `config_en`, `boot_done`, `gap_cnt` and `boot_idx` all go to 0.
  - FIFO pointers and count go to 0, so the FIFO is empty.
  - Consequently `cmd_ready` = 1 and `busy` = 1 during and after reset.
- Issue rule, evaluated every cycle:
  - If `gap_cnt == 0` and a write is pending, the next edge loads `config_addr`/`config_data`, sets `config_en` = 1 and sets `gap_cnt` = `GAP_CYCLES`.
  - If `gap_cnt != 0`, the next edge decrements `gap_cnt` and drives `config_en` = 0.
  - If `gap_cnt == 0` and nothing is pending, `config_en` = 0.
- Pending source during boot (`boot_done` = 0):
  - The pending write is boot entry `boot_idx`, for addresses 0, 1, 2, 3 in order.
  - The edge that issues entry 3 also sets `boot_done` = 1.
  - The FIFO is never popped during boot.
- Pending source after boot: the FIFO head, whenever the FIFO is non-empty. Issuing a write pops the head on the same edge.
- Push: `cmd_valid & cmd_ready` at an edge writes `cmd_data` into the FIFO.
  - Pushes are accepted during boot and buffered.
  - A simultaneous push and pop when not full is legal: the count is unchanged.
  - When full, `cmd_ready` = 0 even if a pop happens in the same cycle.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.
- `config_addr`/`config_data` hold their last written value between strobes; they do not return to 0.
- Writes carry no per-address filtering; addresses 0..3 are all passed through unchanged.

## Timing
- Boot:
  - The first rising edge after `rst` deasserts issues boot write 0.
  - Boot strobes are spaced `GAP_CYCLES` low cycles apart.
  - `boot_done` rises on edge 3·(`GAP_CYCLES`+1)+1 after reset release, the same edge as the last boot strobe.
- Command latency:
  - A command accepted on edge t, into an empty FIFO with the loader otherwise idle, is strobed at edge t+1.
  - `config_en` is therefore high in the cycle after t+1.
  - There is no bypass path.
- Throughput: one write per `GAP_CYCLES`+1 cycles. With `GAP_CYCLES` = 0, back-to-back strobes occur every cycle.
- Reset asserted mid-write or mid-gap:
  - Outputs clear immediately, without waiting for a clock edge.
  - Queued commands are discarded.
  - The boot sequence restarts after reset release.

## Test plan
- Reset release with default parameters and no commands:
  - Strobes at edges 1, 4, 7, 10.
  - (addr, data) = (0,0), (1,1), (2,2), (3,0).
  - `boot_done` rises at edge 10; `busy` falls after the final gap drains.
- Command during boot: push `cmd_data` = 4'b0111 at edge 2.
  - The command is buffered.
  - It is strobed as addr 1, data 3 on edge 13, the first issue slot after the last boot strobe plus the gap.
- Full FIFO: with `FIFO_DEPTH` = 4 and `GAP_CYCLES` = 15, push 5 commands post-boot.
  - `cmd_ready` drops after the 4th push is stored alongside an in-flight pop.
  - All accepted commands are strobed in order, 16 cycles apart.
  - The 5th command is accepted only after a pop frees an entry.
- `GAP_CYCLES` = 0: stream 6 commands with `cmd_valid` held high.
  - `config_en` stays high for 6 consecutive cycles.
  - Data matches push order.
  - The count never exceeds 1.
- Async reset asserted mid-gap with 2 commands queued:
  - All outputs are 0 within the reset cycle.
  - After release the boot sequence repeats.
  - The queued commands never appear.

Source files
------------

// File: rtl/config_loader_if.sv
// config_loader_if: host command handshake plus configuration write bus
interface config_loader_if;
   logic       cmd_valid;
   logic [3:0] cmd_data;
   logic       cmd_ready;
   logic [1:0] config_addr;
   logic [1:0] config_data;
   logic       config_en;
   logic       boot_done;
   logic       busy;
   modport master (
      input  cmd_valid, cmd_data,
      output cmd_ready, config_addr, config_data, config_en, boot_done, busy
   );
   modport slave (
      output cmd_valid, cmd_data,
      input  cmd_ready, config_addr, config_data, config_en, boot_done, busy
   );
endinterface

// File: rtl/config_loader.sv
// config_loader: replays a boot write sequence, then drains host commands with idle gaps
module config_loader #(
   parameter logic [1:0] BOOT_CH0    = 2'h0,
   parameter logic [1:0] BOOT_CH1    = 2'h1,
   parameter logic [1:0] BOOT_CH2    = 2'h2,
   parameter logic       BOOT_CRC_EN = 1'b0,
   parameter int         GAP_CYCLES  = 2,
   parameter int         FIFO_DEPTH  = 4
) (
   input logic              clk,
   input logic              rst,
   config_loader_if.master  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {S_BOOT, S_RUN} state_t;
   state_t         state, state_nx;
   logic [1:0]     boot_idx;
   logic [3:0]     gap_cnt;
   logic [3:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           full, empty, push, pop, issue;
   logic [1:0]     boot_data, nx_addr, nx_data;
   assign full          = count == (AW+1)'(FIFO_DEPTH);
   assign empty         = count == '0;
   assign push          = bus.cmd_valid & ~full;
   assign bus.cmd_ready = ~full;
   assign bus.boot_done = state == S_RUN;
   assign bus.busy      = (state != S_RUN) | ~empty | (gap_cnt != 4'd0) | bus.config_en;
   // phase register: boot replay until the last boot entry is issued
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_BOOT;
      else     state <= state_nx;
   // leave boot on the edge that issues the final boot entry
   always_comb state_nx = (state == S_BOOT && issue && boot_idx == 2'd3) ? S_RUN : state;
   // issue decision and the write selected from boot table or FIFO head
   always_comb begin
      boot_data = boot_idx == 2'd0 ? BOOT_CH0 :
                  boot_idx == 2'd1 ? BOOT_CH1 :
                  boot_idx == 2'd2 ? BOOT_CH2 : {1'b0, BOOT_CRC_EN};
      issue     = gap_cnt == 4'd0 && (state == S_BOOT || !empty);
      pop       = issue && state == S_RUN;
      nx_addr   = state == S_BOOT ? boot_idx  : mem[rd_ptr][3:2];
      nx_data   = state == S_BOOT ? boot_data : mem[rd_ptr][1:0];
   end
   // write strobe, held address/data, gap countdown and boot progress
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.config_addr <= '0;
         bus.config_data <= '0;
         bus.config_en   <= 1'b0;
         gap_cnt         <= '0;
         boot_idx        <= '0;
      end else begin
         bus.config_en <= issue;
         gap_cnt       <= issue ? 4'(GAP_CYCLES) : (gap_cnt != 4'd0 ? gap_cnt - 4'd1 : gap_cnt);
         if (issue) begin
            bus.config_addr <= nx_addr;
            bus.config_data <= nx_data;
         end
         if (issue && state == S_BOOT) boot_idx <= boot_idx + 2'd1;
      end
   // FIFO pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // FIFO storage needs no reset; occupancy gates every read
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.cmd_data;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized and directed checks of config_loader against a queue model
module tb_config_loader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_data = '0;
   int         sel = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         edge_n = 0;
   int         se[$];
   int         gap_m = 2;
   logic [3:0] fq[$];
   logic [3:0] bq[$];
   int         cool;
   logic       m_en, m_done;
   logic [1:0] m_addr, m_data;
   logic       o_en, o_done, o_ready, o_busy;
   logic [1:0] o_addr, o_data;
   config_loader_if ia();
   config_loader_if ib();
   config_loader_if ic();
   assign ia.cmd_valid = cmd_valid && sel == 0;
   assign ib.cmd_valid = cmd_valid && sel == 1;
   assign ic.cmd_valid = cmd_valid && sel == 2;
   assign ia.cmd_data  = cmd_data;
   assign ib.cmd_data  = cmd_data;
   assign ic.cmd_data  = cmd_data;
   config_loader u_a (.clk(clk), .rst(rst), .bus(ia));
   config_loader #(.GAP_CYCLES(0))  u_b (.clk(clk), .rst(rst), .bus(ib));
   config_loader #(.GAP_CYCLES(15)) u_c (.clk(clk), .rst(rst), .bus(ic));
   always #5 clk = ~clk;
   always_comb begin
      o_en    = sel == 0 ? ia.config_en   : sel == 1 ? ib.config_en   : ic.config_en;
      o_addr  = sel == 0 ? ia.config_addr : sel == 1 ? ib.config_addr : ic.config_addr;
      o_data  = sel == 0 ? ia.config_data : sel == 1 ? ib.config_data : ic.config_data;
      o_done  = sel == 0 ? ia.boot_done   : sel == 1 ? ib.boot_done   : ic.boot_done;
      o_ready = sel == 0 ? ia.cmd_ready   : sel == 1 ? ib.cmd_ready   : ic.cmd_ready;
      o_busy  = sel == 0 ? ia.busy        : sel == 1 ? ib.busy        : ic.busy;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (sel=%0d edge=%0d)", tag, obs, exp, sel, edge_n);
      end
   endtask
   task automatic model_reset();
      bq = '{4'b0000, 4'b0101, 4'b1010, 4'b1100};
      fq.delete();
      cool = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_done = 1'b0;
   endtask
   task automatic model_edge();
      logic [3:0] w;
      bit p;
      p = cmd_valid && fq.size() < 4;
      if (cool > 0) begin
         cool--; m_en = 1'b0;
      end else if (bq.size() > 0) begin
         w = bq.pop_front(); {m_addr, m_data} = w; m_en = 1'b1; cool = gap_m;
         if (bq.size() == 0) m_done = 1'b1;
      end else if (fq.size() > 0) begin
         w = fq.pop_front(); {m_addr, m_data} = w; m_en = 1'b1; cool = gap_m;
      end else m_en = 1'b0;
      if (p) fq.push_back(cmd_data);
   endtask
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      edge_n++;
      if (o_en) se.push_back(edge_n);
      chk("config_en",   32'(o_en),    32'(m_en));
      chk("config_addr", 32'(o_addr),  32'(m_addr));
      chk("config_data", 32'(o_data),  32'(m_data));
      chk("boot_done",   32'(o_done),  32'(m_done));
      chk("cmd_ready",   32'(o_ready), 32'(fq.size() < 4));
      chk("busy",        32'(o_busy),  32'(!m_done || fq.size() != 0 || cool != 0 || m_en));
   endtask
   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic do_reset();
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_en",    32'(o_en),    32'd0);
      chk("rst_addr",  32'(o_addr),  32'd0);
      chk("rst_data",  32'(o_data),  32'd0);
      chk("rst_done",  32'(o_done),  32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_busy",  32'(o_busy),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      edge_n = 0;
      se.delete();
   endtask
   initial begin
      int exp_e[4] = '{1, 4, 7, 10};
      int acc, guard;
      // boot sequence alone, default parameters
      sel = 0; gap_m = 2;
      do_reset();
      steps(14);
      chk("boot_strobes", 32'(se.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("boot_edge", 32'(i < se.size() ? se[i] : -1), 32'(exp_e[i]));
      // command pushed during boot is strobed after boot plus the gap
      do_reset();
      step();
      cmd_valid = 1'b1; cmd_data = 4'b0111;
      step();
      cmd_valid = 1'b0;
      steps(14);
      chk("boot_cmd_edge", 32'(se.size() > 4 ? se[4] : -1), 32'd13);
      // long gap: overfill the FIFO post-boot
      sel = 2; gap_m = 15;
      do_reset();
      steps(70);
      acc = 0; guard = 0;
      cmd_valid = 1'b1; cmd_data = 4'($urandom);
      while (acc < 5 && guard < 200) begin
         if (fq.size() < 4) acc++;
         step();
         guard++;
         cmd_data = 4'($urandom);
      end
      chk("full_accepts", 32'(acc), 32'd5);
      cmd_valid = 1'b0;
      steps(100);
      chk("full_strobes", 32'(se.size()), 32'd9);
      for (int i = 5; i < se.size(); i++) chk("full_spacing", 32'(se[i] - se[i-1]), 32'd16);
      // zero gap: back-to-back streaming
      sel = 1; gap_m = 0;
      do_reset();
      steps(10);
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_data = 4'(i * 5 + 3);
         step();
      end
      cmd_valid = 1'b0;
      steps(4);
      chk("stream_count", 32'(se.size()), 32'd10);
      chk("stream_run", 32'(se.size() == 10 ? se[9] - se[4] : -1), 32'd5);
      // reset mid-gap with two commands queued
      sel = 0; gap_m = 2;
      do_reset();
      steps(12);
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_data = 4'(9 + i);
         step();
      end
      chk("queued_before_rst", 32'(fq.size()), 32'd2);
      do_reset();
      steps(16);
      chk("post_rst_strobes", 32'(se.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("post_rst_edge", 32'(i < se.size() ? se[i] : -1), 32'(exp_e[i]));
      // randomized traffic on every instance
      for (int s = 0; s < 3; s++) begin
         sel = s; gap_m = s == 0 ? 2 : s == 1 ? 0 : 15;
         do_reset();
         for (int i = 0; i < 400; i++) begin
            cmd_valid = $urandom_range(0, 1) == 1;
            cmd_data  = 4'($urandom);
            step();
            if ($urandom_range(0, 199) == 0) do_reset();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
